// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer
//   Byte-level I2C write engine. On an accepted start it latches a device
//   address (forced to write), a register address and a register value, then
//   issues START, three bytes (each followed by an ACK slot) and STOP on the
//   bus. SCL is generated internally from clk_in. Each SCL quarter-bit phase
//   lasts CLK_DIV clk_in cycles.
// Ports:
//   clk_in    - system clock, rising edge
//   reset_not - synchronous active-low reset
//   start     - level request, accepted only while ready=1
//   dev_addr  - [7:1] 7-bit device address, bit0 ignored
//   reg_data  - [15:8] register address, [7:0] register value
//   ready     - idle and able to accept start
//   ack       - last completed transaction was ACKed on every byte
//   states    - debug {last ACK sample, byte index, one-hot FSM state}
//   i2c_sda   - open-drain data line (drives 0 or high-Z only)
//   i2c_scl   - push-pull clock line
module i2c_reg_writer #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clk_in,
  input  logic        reset_not,
  input  logic        start,
  input  logic [7:0]  dev_addr,
  input  logic [15:0] reg_data,
  output logic        ready,
  output logic        ack,
  output logic [7:0]  states,
  inout  wire         i2c_sda,
  output logic        i2c_scl
);

  localparam int unsigned   DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'h01,
    S_START = 5'h02,
    S_BIT   = 5'h04,
    S_ACK   = 5'h08,
    S_STOP  = 5'h10
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          sample_q, sample_d;
  logic          ok_q, ok_d;
  logic          ack_q, ack_d;
  logic          tick;
  logic          sda_low;

  always_ff @(posedge clk_in) begin
    if (!reset_not) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shreg_q  <= '0;
      sample_q <= 1'b0;
      ok_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      ok_q     <= ok_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    tick     = (div_q == DIV_LAST);
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shreg_d  = shreg_q;
    sample_d = sample_q;
    ok_d     = ok_q;
    ack_d    = ack_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Masking bit0 forces the R/W bit to write.
          shreg_d = {dev_addr & 8'hFE, reg_data};
          ack_d   = 1'b0;
          ok_d    = 1'b0;
          byte_d  = '0;
          bit_d   = '0;
          phase_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase_q == 2'd1) begin
            phase_d = '0;
            state_d = S_BIT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            // Shift after every bit so the next byte lands at the top
            // by the time the ACK slot ends.
            shreg_d = {shreg_q[22:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) sample_d = i2c_sda;
          if (phase_q == 2'd3) begin
            if (!sample_q && byte_q != 2'd2) begin
              byte_d  = byte_q + 2'd1;
              state_d = S_BIT;
            end else begin
              ok_d    = !sample_q;
              state_d = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (phase_q == 2'd2) begin
            phase_d = '0;
            ack_d   = ok_q;
            state_d = S_IDLE;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sda_low = 1'b0;
    i2c_scl = 1'b1;
    case (state_q)
      S_START: sda_low = phase_q[0];
      S_BIT: begin
        i2c_scl = phase_q[1];
        sda_low = ~shreg_q[23];
      end
      S_ACK:   i2c_scl = phase_q[1];
      S_STOP: begin
        i2c_scl = (phase_q != 2'd0);
        sda_low = (phase_q != 2'd2);
      end
      default: ;
    endcase
  end

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign ready   = (state_q == S_IDLE);
  assign ack     = ack_q;
  assign states  = {sample_q, byte_q, state_q};

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed bench for i2c_reg_writer with CLK_DIV=4 and a small I2C slave
// model that decodes bytes, counts SCL pulses and STOPs, and ACKs or NACKs.
module tb_i2c_reg_writer;

  localparam int unsigned CLK_DIV = 4;

  logic        clk_in = 1'b0;
  logic        reset_not;
  logic        start;
  logic [7:0]  dev_addr;
  logic [15:0] reg_data;
  logic        ready;
  logic        ack;
  logic [7:0]  states;
  logic        i2c_scl;
  wire         i2c_sda;
  logic        slave_pull;

  pullup (i2c_sda);
  assign i2c_sda = slave_pull ? 1'b0 : 1'bz;

  i2c_reg_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in    (clk_in),
    .reset_not (reset_not),
    .start     (start),
    .dev_addr  (dev_addr),
    .reg_data  (reg_data),
    .ready     (ready),
    .ack       (ack),
    .states    (states),
    .i2c_sda   (i2c_sda),
    .i2c_scl   (i2c_scl)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: byte index to NACK (-1 = ACK all)
  int         nack_byte = -1;
  int         falls = 0, nbytes = 0, bitcnt = 0, stops = 0;
  logic [7:0] shreg = '0;
  logic [7:0] rx [3];
  logic       scl_p = 1'b1, sda_p = 1'b1, in_xfer = 1'b0;

  initial begin
    slave_pull = 1'b0;
    forever begin
      @(negedge clk_in);
      if (scl_p && i2c_scl && sda_p && !i2c_sda) begin
        in_xfer = 1'b1; falls = 0; nbytes = 0; bitcnt = 0;
        for (int i = 0; i < 3; i++) rx[i] = 8'hEE;
      end else if (scl_p && i2c_scl && !sda_p && i2c_sda) begin
        in_xfer = 1'b0; stops++;
      end else if (in_xfer && !scl_p && i2c_scl) begin
        if (bitcnt < 8) shreg = {shreg[6:0], i2c_sda};
        bitcnt++;
      end else if (in_xfer && scl_p && !i2c_scl) begin
        falls++;
        if (bitcnt == 8) begin
          if (nbytes < 3) rx[nbytes] = shreg;
          slave_pull = (nbytes != nack_byte);
          nbytes++;
        end else if (bitcnt == 9) begin
          slave_pull = 1'b0;
          bitcnt = 0;
        end
      end
      scl_p = i2c_scl;
      sda_p = i2c_sda;
    end
  end

  task automatic launch(input logic [7:0] da, input logic [15:0] rd);
    dev_addr = da;
    reg_data = rd;
    start    = 1'b1;
    for (int i = 0; i < 8 && ready; i++) @(negedge clk_in);
    check("accepted", ready, 1'b0);
  endtask

  // Counts negedges with ready=0, starting from pre already counted.
  task automatic wait_done(input int pre, output int low);
    int guard;
    guard = 0;
    low   = pre;
    @(negedge clk_in);
    while (!ready && guard < 2000) begin
      low++;
      guard++;
      @(negedge clk_in);
    end
    check("done_in_budget", ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, s0;
    reset_not = 1'b0;
    start     = 1'b0;
    dev_addr  = '0;
    reg_data  = '0;
    repeat (3) @(negedge clk_in);
    check("rst_ready",  ready,   1'b1);
    check("rst_ack",    ack,     1'b0);
    check("rst_states", states,  8'h01);
    check("rst_scl",    i2c_scl, 1'b1);
    check("rst_sda",    i2c_sda, 1'b1);
    reset_not = 1'b1;
    @(negedge clk_in);

    // Full success
    nack_byte = -1; s0 = stops;
    launch(8'h72, 16'h9803);
    start = 1'b0;
    wait_done(1, low);
    check("t1_low",    low,       452);
    check("t1_pulses", falls - 1, 27);
    check("t1_b0",     rx[0],     8'h72);
    check("t1_b1",     rx[1],     8'h98);
    check("t1_b2",     rx[2],     8'h03);
    check("t1_ack",    ack,       1'b1);
    check("t1_states", states,    8'h41);
    check("t1_stops",  stops,     s0 + 1);

    // NACK on address byte
    nack_byte = 0;
    launch(8'h72, 16'h9803);
    start = 1'b0;
    wait_done(1, low);
    check("t2_low",    low,       164);
    check("t2_pulses", falls - 1, 9);
    check("t2_nbytes", nbytes,    1);
    check("t2_b0",     rx[0],     8'h72);
    check("t2_ack",    ack,       1'b0);
    check("t2_states", states,    8'h81);

    // NACK on data byte
    nack_byte = 2;
    launch(8'h72, 16'hFA7D);
    start = 1'b0;
    wait_done(1, low);
    check("t3_low",    low,       452);
    check("t3_pulses", falls - 1, 27);
    check("t3_b0",     rx[0],     8'h72);
    check("t3_b1",     rx[1],     8'hFA);
    check("t3_b2",     rx[2],     8'h7D);
    check("t3_ack",    ack,       1'b0);
    check("t3_states", states,    8'hC1);

    // start pulsed while busy, inputs changed mid-transaction
    nack_byte = -1;
    launch(8'h72, 16'h9803);
    start = 1'b0;
    repeat (20) @(negedge clk_in);
    start    = 1'b1;
    reg_data = 16'h0000;
    dev_addr = 8'h00;
    repeat (3) @(negedge clk_in);
    start = 1'b0;
    check("t4_busy", ready, 1'b0);
    wait_done(24, low);
    check("t4_low", low,   452);
    check("t4_b0",  rx[0], 8'h72);
    check("t4_b1",  rx[1], 8'h98);
    check("t4_b2",  rx[2], 8'h03);
    check("t4_ack", ack,   1'b1);

    // start held through two transactions
    launch(8'h72, 16'h9803);
    dev_addr = 8'h3D;
    reg_data = 16'h55AA;
    wait_done(1, low);
    check("t5_low1",  low,   452);
    check("t5_ack1",  ack,   1'b1);
    check("t5_b0_1",  rx[0], 8'h72);
    @(negedge clk_in);
    check("t5_reaccept",   ready, 1'b0);
    check("t5_ack_clear",  ack,   1'b0);
    start = 1'b0;
    wait_done(1, low);
    check("t5_low2", low,   452);
    check("t5_b0_2", rx[0], 8'h3C);
    check("t5_b1_2", rx[1], 8'h55);
    check("t5_b2_2", rx[2], 8'hAA);
    check("t5_ack2", ack,   1'b1);

    // Reset mid-byte (bit 3 of the address byte, SCL low)
    s0 = stops;
    launch(8'h72, 16'h9803);
    start = 1'b0;
    repeat (56) @(negedge clk_in);
    check("t6_scl_pre", i2c_scl, 1'b0);
    reset_not = 1'b0;
    @(negedge clk_in);
    check("t6_scl",    i2c_scl, 1'b1);
    check("t6_sda",    i2c_sda, 1'b1);
    check("t6_ready",  ready,   1'b1);
    check("t6_ack",    ack,     1'b0);
    check("t6_states", states,  8'h01);
    reset_not = 1'b1;
    repeat (20) @(negedge clk_in);
    check("t6_no_stop", stops, s0);
    check("t6_idle",    ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
